// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - FIFO write-side controller; optional almost_full via `define ALMOST_FULL_EN
module fifo_write_ctrl #(
    parameter int SIZE = 4
`ifdef ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_TH = 2
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            write_req,
    input  logic            clear_overflow,
    input  logic [SIZE-1:0] read_pointer,
    input  logic            read_wrap,
    output logic [SIZE-1:0] write_pointer,
    output logic            write_wrap,
    output logic            write_en,
    output logic            full_flag,
    output logic [SIZE:0]   level,
    output logic            overflow
`ifdef ALMOST_FULL_EN
    ,
    output logic            almost_full
`endif
);

    // Pointers extended with their wrap bit; the difference of the two is the
    // fill level, and one increment of the extended write position advances
    // the address and toggles the wrap bit together on rollover.
    logic [SIZE:0] write_pos;
    logic [SIZE:0] read_pos;

    assign write_pos = {write_wrap, write_pointer};
    assign read_pos  = {read_wrap, read_pointer};

    // Same address, opposite lap: the writer is a full lap ahead of the reader.
    assign full_flag = (write_pointer == read_pointer) && (write_wrap != read_wrap);
    assign write_en  = write_req & ~full_flag;
    assign level     = write_pos - read_pos;

    // Write pointer and wrap bit advance on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_pointer <= '0;
            write_wrap    <= 1'b0;
        end else if (write_en) begin
            {write_wrap, write_pointer} <= write_pos + 1'b1;
        end
    end

    // Sticky overflow; a fresh overflow in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (write_req && full_flag) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef ALMOST_FULL_EN
    localparam logic [SIZE:0] DEPTH = {1'b1, {SIZE{1'b0}}};

    logic [SIZE:0] free_count;

    // Free-slot count against the threshold; full is always almost full.
    always_comb begin
        free_count  = DEPTH - level;
        almost_full = full_flag | (free_count <= ALMOST_FULL_TH[SIZE:0]);
    end
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - self-checking bench for fifo_write_ctrl
module tb_fifo_write_ctrl;

    localparam int SIZE  = 4;
    localparam int DEPTH = 16;
    localparam int AF_TH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            write_req;
    logic            clear_overflow;
    logic [SIZE-1:0] read_pointer;
    logic            read_wrap;
    logic [SIZE-1:0] write_pointer;
    logic            write_wrap;
    logic            write_en;
    logic            full_flag;
    logic [SIZE:0]   level;
    logic            overflow;
`ifdef ALMOST_FULL_EN
    logic            almost_full;
`endif

    fifo_write_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_req      (write_req),
        .clear_overflow (clear_overflow),
        .read_pointer   (read_pointer),
        .read_wrap      (read_wrap),
        .write_pointer  (write_pointer),
        .write_wrap     (write_wrap),
        .write_en       (write_en),
        .full_flag      (full_flag),
        .level          (level),
        .overflow       (overflow)
`ifdef ALMOST_FULL_EN
        ,
        .almost_full    (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic     wreq;
        logic     clr;
        int       rptr;
        logic     rwrap;
        int       e_wp;
        logic     e_ww;
        logic     e_en;
        logic     e_full;
        int       e_level;
        logic     e_ovf;
    } vec_t;

    vec_t vecs[23];

    // Behavioural model: total pushes and pops since reset, plus sticky overflow.
    int  wr_cnt;
    int  rd_cnt;
    bit  m_ovf;

    task automatic model_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        m_ovf  = 0;
    endtask

    // One clock of stimulus from a negedge: drive, check before the edge, step model.
    task automatic cycle(input bit w, input bit r, input bit c);
        int occ;
        bit e_full;
        bit e_en;
        write_req      = w;
        clear_overflow = c;
        read_pointer   = SIZE'(rd_cnt % DEPTH);
        read_wrap      = ((rd_cnt / DEPTH) % 2) == 1;
        #1;
        occ    = wr_cnt - rd_cnt;
        e_full = (occ == DEPTH);
        e_en   = w && !e_full;
        check("m_wp",    int'(write_pointer), wr_cnt % DEPTH);
        check("m_wrap",  int'(write_wrap),    (wr_cnt / DEPTH) % 2);
        check("m_level", int'(level),         occ);
        check("m_full",  int'(full_flag),     int'(e_full));
        check("m_en",    int'(write_en),      int'(e_en));
        check("m_ovf",   int'(overflow),      int'(m_ovf));
`ifdef ALMOST_FULL_EN
        check("m_afull", int'(almost_full),   int'((DEPTH - occ) <= AF_TH));
`endif
        @(posedge clk);
        if (e_en) wr_cnt++;
        if (w && e_full) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (r && occ > 0) rd_cnt++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle with the read side reset together.
    task automatic mid_reset(input bit w);
        #2;
        write_req      = w;
        rst_n          = 1'b0;
        read_pointer   = '0;
        read_wrap      = 1'b0;
        #1;
        check("rst_wp",    int'(write_pointer), 0);
        check("rst_wrap",  int'(write_wrap),    0);
        check("rst_level", int'(level),         0);
        check("rst_full",  int'(full_flag),     0);
        check("rst_ovf",   int'(overflow),      0);
        check("rst_en",    int'(write_en),      int'(w));
        @(posedge clk);
        #1;
        check("rst_hold_wp", int'(write_pointer), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        write_req      = 1'b0;
        clear_overflow = 1'b0;
        read_pointer   = '0;
        read_wrap      = 1'b0;

        // Directed table: reset state, fill to full, overflow, clear, read frees a slot.
        vecs[0] = '{1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        for (int i = 0; i < 16; i++)
            vecs[i+1] = '{1'b1, 1'b0, 0, 1'b0, i, 1'b0, 1'b1, 1'b0, i, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 15, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 15, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 16, 1'b0};

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 23; i++) begin
            write_req      = vecs[i].wreq;
            clear_overflow = vecs[i].clr;
            read_pointer   = SIZE'(vecs[i].rptr);
            read_wrap      = vecs[i].rwrap;
            #1;
            check($sformatf("t%0d_wp", i),    int'(write_pointer), vecs[i].e_wp);
            check($sformatf("t%0d_wrap", i),  int'(write_wrap),    int'(vecs[i].e_ww));
            check($sformatf("t%0d_en", i),    int'(write_en),      int'(vecs[i].e_en));
            check($sformatf("t%0d_full", i),  int'(full_flag),     int'(vecs[i].e_full));
            check($sformatf("t%0d_level", i), int'(level),         vecs[i].e_level);
            check($sformatf("t%0d_ovf", i),   int'(overflow),      int'(vecs[i].e_ovf));
            @(posedge clk);
            @(negedge clk);
        end

        // Full with overflow request and clear in the same cycle: set wins.
        write_req      = 1'b1;
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        check("prio_ovf_set", int'(overflow), 1);
        check("prio_wp_hold", int'(write_pointer), 1);
        @(negedge clk);
        write_req = 1'b0;
        @(posedge clk);
        #1;
        check("prio_ovf_clr", int'(overflow), 0);
        @(negedge clk);
        clear_overflow = 1'b0;

        // Fill, then continuous write with a read every cycle across the wrap.
        mid_reset(1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0);

        // Randomized traffic against the model.
        mid_reset(1'b0);
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 8) == 0);
        for (int i = 0; i < 200; i++)
            cycle(($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 6) == 0);

        // Reset mid-burst at level 9, then writes resume from address 0.
        mid_reset(1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
        check("pre_rst_level", int'(level), 9);
        mid_reset(1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
